// File: rtl/serdes_clk_div_tree.sv
// Power-of-two clock divider tree: one shared counter drives NumStages aligned, maskable
// divided clocks with synchronised glitch-free start/stop. Optional o_frame: SERDES_CLK_DIV_FRAME_EN.
module serdes_clk_div_tree #(
    parameter int NumStages  = 4,
    parameter int SyncStages = 2
) (
    input  logic                 o_clk_ref,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [NumStages-1:0] i_clk_mask,
    output logic [NumStages-1:0] o_clk,
    output logic                 o_active
`ifdef SERDES_CLK_DIV_FRAME_EN
    ,
    output logic                 o_frame
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [NumStages-1:0] CNT_MAX = {NumStages{1'b1}};
    localparam logic [NumStages-1:0] CNT_ONE = 1;

    state_t                state_reg;
    state_t                state_next;
    logic [NumStages-1:0]  cnt_reg;
    logic [NumStages-1:0]  cnt_next;
    logic [NumStages-1:0]  mask_reg;
    logic [NumStages-1:0]  mask_next;
    logic [NumStages-1:0]  clk_next;
    logic [SyncStages-1:0] sync_reg;
    logic                  en_s;
    logic                  cnt_wrap;
    logic                  active_next;

    assign en_s     = sync_reg[SyncStages-1];
    assign cnt_wrap = (cnt_reg == CNT_MAX);

    always_ff @(posedge o_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], i_en};
        end
    end

    // Mask only reloads where every counter bit returns to 0, so no output is truncated.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mask_next  = mask_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (en_s) begin
                    state_next = ST_RUN;
                    cnt_next   = CNT_ONE;
                    mask_next  = i_clk_mask;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (cnt_wrap) begin
                    mask_next = i_clk_mask;
                end
                if (!en_s) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (en_s) begin
                    state_next = ST_RUN;
                    if (cnt_wrap) begin
                        mask_next = i_clk_mask;
                    end
                end else if (cnt_wrap) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign active_next = (state_next != ST_IDLE);

    // Outputs are flops of the next-state AND, keeping them glitch-free.
    genvar gi;
    generate
        for (gi = 0; gi < NumStages; gi++) begin : g_out
            assign clk_next[gi] = cnt_next[gi] & mask_next[gi];
        end
    endgenerate

    always_ff @(posedge o_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mask_reg  <= '0;
            o_clk     <= '0;
            o_active  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mask_reg  <= mask_next;
            o_clk     <= clk_next;
            o_active  <= active_next;
        end
    end

`ifdef SERDES_CLK_DIV_FRAME_EN
    always_ff @(posedge o_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            o_frame <= 1'b0;
        end else begin
            o_frame <= active_next && (cnt_next == CNT_MAX);
        end
    end
`endif

endmodule

// File: tb/tb_serdes_clk_div_tree.sv
// Directed self-checking bench for serdes_clk_div_tree (NumStages=4, SyncStages=2).
module tb_serdes_clk_div_tree;

    logic       o_clk_ref;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_clk_mask;
    logic [3:0] o_clk;
    logic       o_active;
`ifdef SERDES_CLK_DIV_FRAME_EN
    logic       o_frame;
`endif

    int         total;
    int         bad;
    logic [3:0] exp_cnt;
    logic [3:0] exp_mask;

    serdes_clk_div_tree #(
        .NumStages (4),
        .SyncStages(2)
    ) dut (
        .o_clk_ref (o_clk_ref),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_clk_mask(i_clk_mask),
        .o_clk     (o_clk),
        .o_active  (o_active)
`ifdef SERDES_CLK_DIV_FRAME_EN
        ,
        .o_frame   (o_frame)
`endif
    );

    initial o_clk_ref = 1'b0;
    always #5 o_clk_ref = ~o_clk_ref;

    task automatic step;
        @(posedge o_clk_ref);
        #1;
    endtask

    task automatic test_reset;
        i_rst      = 1'b1;
        i_en       = 1'b0;
        i_clk_mask = 4'hF;
        exp_cnt    = 4'd0;
        exp_mask   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (o_clk !== 4'b0000 || o_active !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: o_clk=%b active=%b required o_clk=0000 active=0", o_clk, o_active);
            end
        end
        i_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if (o_clk !== 4'b0000 || o_active !== 1'b0) begin
                bad++;
                $display("FAIL idle: cycle %0d o_clk=%b active=%b required o_clk=0000 active=0", i, o_clk, o_active);
            end
`ifdef SERDES_CLK_DIV_FRAME_EN
            total++;
            if (o_frame !== 1'b0) begin
                bad++;
                $display("FAIL idle_frame: o_frame=%b required 0", o_frame);
            end
`endif
        end
        $display("[tb] test_reset done");
    endtask

    task automatic test_start;
        i_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (i < 3) begin
                if (o_active !== 1'b0 || o_clk !== 4'd0) begin
                    bad++;
                    $display("FAIL start_latency: cycle %0d active=%b o_clk=%b required 0/0000", i, o_active, o_clk);
                end
            end else begin
                if (o_active !== 1'b1 || o_clk !== 4'd1) begin
                    bad++;
                    $display("FAIL start_first: active=%b o_clk=%b required 1/0001", o_active, o_clk);
                end
            end
        end
        exp_cnt = 4'd1;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            total++;
            if (o_clk !== exp_cnt || o_active !== 1'b1) begin
                bad++;
                $display("FAIL ratio: o_clk=%b active=%b required o_clk=%b active=1", o_clk, o_active, exp_cnt);
            end
        end
        $display("[tb] test_start done");
    endtask

    task automatic test_stop;
        while (exp_cnt != 4'd5) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            total++;
            if (o_clk !== exp_cnt) begin
                bad++;
                $display("FAIL stop_pre: o_clk=%b required %b", o_clk, exp_cnt);
            end
        end
        i_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            total++;
            if (o_clk !== exp_cnt || o_active !== (exp_cnt != 4'd0)) begin
                bad++;
                $display("FAIL stop_drain: o_clk=%b active=%b required o_clk=%b active=%b",
                         o_clk, o_active, exp_cnt, (exp_cnt != 4'd0));
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (o_clk !== 4'd0 || o_active !== 1'b0) begin
                bad++;
                $display("FAIL stop_idle: o_clk=%b active=%b required 0000/0", o_clk, o_active);
            end
        end
        $display("[tb] test_stop done");
    endtask

    task automatic test_mask;
        i_en       = 1'b1;
        i_clk_mask = 4'hF;
        step();
        step();
        step();
        exp_cnt  = 4'd1;
        exp_mask = 4'hF;
        total++;
        if (o_active !== 1'b1 || o_clk !== 4'd1) begin
            bad++;
            $display("FAIL mask_restart: active=%b o_clk=%b required 1/0001", o_active, o_clk);
        end
        while (exp_cnt != 4'd3) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
        end
        i_clk_mask = 4'h5;
        for (int i = 0; i < 48; i++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            if (exp_cnt == 4'd0) exp_mask = i_clk_mask;
            total++;
            if (o_clk !== (exp_cnt & exp_mask)) begin
                bad++;
                $display("FAIL mask: cnt=%0d o_clk=%b required %b", exp_cnt, o_clk, exp_cnt & exp_mask);
            end
            if (exp_cnt == 4'd2 && exp_mask == 4'h5) i_clk_mask = 4'hF;
        end
        $display("[tb] test_mask done");
    endtask

    task automatic test_drain_reenable;
        while (exp_cnt != 4'd2) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
        end
        i_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
        end
        i_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            total++;
            if (o_clk !== exp_cnt || o_active !== 1'b1) begin
                bad++;
                $display("FAIL drain_reenable: o_clk=%b active=%b required o_clk=%b active=1", o_clk, o_active, exp_cnt);
            end
        end
        $display("[tb] test_drain_reenable done");
    endtask

`ifdef SERDES_CLK_DIV_FRAME_EN
    task automatic test_frame;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            total++;
            if (o_frame !== (exp_cnt == 4'd15)) begin
                bad++;
                $display("FAIL frame: cnt=%0d o_frame=%b required %b", exp_cnt, o_frame, (exp_cnt == 4'd15));
            end
        end
        $display("[tb] test_frame done");
    endtask
`endif

    task automatic test_reset_mid;
        while (exp_cnt != 4'd9) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
        end
        #3;
        i_rst = 1'b1;
        #1;
        total++;
        if (o_clk !== 4'd0 || o_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: o_clk=%b active=%b required 0000/0", o_clk, o_active);
        end
        step();
        total++;
        if (o_clk !== 4'd0 || o_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: o_clk=%b active=%b required 0000/0", o_clk, o_active);
        end
        i_rst   = 1'b0;
        exp_cnt = 4'd0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i >= 3) exp_cnt = exp_cnt + 4'd1;
            total++;
            if (o_clk !== exp_cnt || o_active !== (i >= 3)) begin
                bad++;
                $display("FAIL reset_restart: cycle %0d o_clk=%b active=%b required o_clk=%b active=%b",
                         i, o_clk, o_active, exp_cnt, (i >= 3));
            end
        end
        $display("[tb] test_reset_mid done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_start();
        test_stop();
        test_mask();
        test_drain_reenable();
`ifdef SERDES_CLK_DIV_FRAME_EN
        test_frame();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
